// File: rtl/leaf_bft_rx.sv
// Receive-side unpacker for a BFT leaf page. Incoming packets are filtered by
// leaf address and steered by port field into per-port FIFOs. Each FIFO drives
// a valid/ready stream. Freed FIFO slots are returned to the sender as credit
// packets.
module leaf_bft_rx #(
  parameter int unsigned NUM_PORTS   = 4,
  parameter int unsigned FIFO_DEPTH  = 16,
  parameter logic [4:0]  LEAF_ADDR   = 5'd1,
  parameter logic [4:0]  CREDIT_DEST = 5'd0
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [48:0]             din_leaf_bft2interface,
  output logic [NUM_PORTS*32-1:0] dout_data,
  output logic [NUM_PORTS-1:0]    dout_valid,
  input  logic [NUM_PORTS-1:0]    dout_ready,
  output logic [48:0]             credit_out,
  input  logic                    credit_ready,
  output logic                    err_overflow,
  output logic                    err_misroute,
  output logic [15:0]             drop_count
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);

  // Pointers and freed-slot counters share the same width: one wrap bit extra.
  typedef logic [AW:0] ptr_t;

  typedef enum logic {StIdle, StSend} state_e;

  logic [48:0] in_q;
  logic        in_vld;
  logic [4:0]  in_addr;
  logic [2:0]  in_port;
  logic        route_ok;
  logic        ovf_drop;
  logic        mis_drop;
  logic        unused_in_cnt;

  logic [31:0] mem_q [NUM_PORTS][FIFO_DEPTH];
  ptr_t        wr_ptr_q [NUM_PORTS];
  ptr_t        rd_ptr_q [NUM_PORTS];
  ptr_t        freed_q  [NUM_PORTS];
  ptr_t        freed_d  [NUM_PORTS];

  logic [NUM_PORTS-1:0] empty;
  logic [NUM_PORTS-1:0] full;
  logic [NUM_PORTS-1:0] push;
  logic [NUM_PORTS-1:0] pop;

  state_e      state_q, state_d;
  logic [2:0]  rr_q, rr_d;
  logic [2:0]  sel_q, sel_d;
  ptr_t        cnt_q, cnt_d;
  logic [48:0] credit_q, credit_d;
  logic        found;
  logic [2:0]  pick;
  ptr_t        pick_cnt;

  logic        err_overflow_q;
  logic        err_misroute_q;
  logic [15:0] drop_count_q;

  assign in_vld        = in_q[48];
  assign in_addr       = in_q[47:43];
  assign in_port       = in_q[42:40];
  // The count field is meaningful only on credit packets.
  assign unused_in_cnt = ^in_q[39:32];
  assign route_ok      = (in_addr == LEAF_ADDR) && (32'(in_port) < NUM_PORTS);

  // FIFO status flags and per-port stream outputs
  always_comb begin
    dout_data = '0;
    for (int p = 0; p < int'(NUM_PORTS); p++) begin
      empty[p] = (wr_ptr_q[p] == rd_ptr_q[p]);
      full[p]  = (wr_ptr_q[p][AW] != rd_ptr_q[p][AW]) &&
                 (wr_ptr_q[p][AW-1:0] == rd_ptr_q[p][AW-1:0]);
      pop[p]   = !empty[p] && dout_ready[p];
      // Gate stale memory contents so an empty port presents zero data.
      if (!empty[p]) begin
        dout_data[p*32 +: 32] = mem_q[p][rd_ptr_q[p][AW-1:0]];
      end
    end
  end

  assign dout_valid = ~empty;

  // Input decode: push, overflow drop (checked before any same-cycle pop) or misroute drop
  always_comb begin
    push     = '0;
    ovf_drop = 1'b0;
    mis_drop = in_vld && !route_ok;
    for (int p = 0; p < int'(NUM_PORTS); p++) begin
      if (in_vld && route_ok && (in_port == 3'(p))) begin
        if (full[p]) begin
          ovf_drop = 1'b1;
        end else begin
          push[p] = 1'b1;
        end
      end
    end
  end

  // Input register, sticky error flags and saturating drop counter
  always_ff @(posedge clk) begin
    if (reset) begin
      in_q           <= '0;
      err_overflow_q <= 1'b0;
      err_misroute_q <= 1'b0;
      drop_count_q   <= '0;
    end else begin
      in_q <= din_leaf_bft2interface;
      if (ovf_drop) begin
        err_overflow_q <= 1'b1;
      end
      if (mis_drop) begin
        err_misroute_q <= 1'b1;
      end
      if ((ovf_drop || mis_drop) && (drop_count_q != 16'hFFFF)) begin
        drop_count_q <= drop_count_q + 16'd1;
      end
    end
  end

  // FIFO storage; contents need no reset because the pointers define validity
  always_ff @(posedge clk) begin
    for (int p = 0; p < int'(NUM_PORTS); p++) begin
      if (push[p]) begin
        mem_q[p][wr_ptr_q[p][AW-1:0]] <= in_q[31:0];
      end
    end
  end

  // FIFO pointer update
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int p = 0; p < int'(NUM_PORTS); p++) begin
        wr_ptr_q[p] <= '0;
        rd_ptr_q[p] <= '0;
      end
    end else begin
      for (int p = 0; p < int'(NUM_PORTS); p++) begin
        if (push[p]) begin
          wr_ptr_q[p] <= wr_ptr_q[p] + ptr_t'(1);
        end
        if (pop[p]) begin
          rd_ptr_q[p] <= rd_ptr_q[p] + ptr_t'(1);
        end
      end
    end
  end

  // Credit FSM next state: round-robin scan in idle, hold packet until accepted in send
  always_comb begin
    state_d  = state_q;
    rr_d     = rr_q;
    sel_d    = sel_q;
    cnt_d    = cnt_q;
    credit_d = credit_q;
    found    = 1'b0;
    pick     = '0;
    pick_cnt = '0;
    for (int p = 0; p < int'(NUM_PORTS); p++) begin
      freed_d[p] = freed_q[p] + ptr_t'(pop[p]);
    end

    unique case (state_q)
      StIdle: begin
        for (int i = 1; i <= int'(NUM_PORTS); i++) begin
          for (int p = 0; p < int'(NUM_PORTS); p++) begin
            if (!found && (p == (int'(rr_q) + i) % int'(NUM_PORTS)) && (freed_q[p] != '0)) begin
              found    = 1'b1;
              pick     = 3'(p);
              pick_cnt = freed_q[p];
            end
          end
        end
        if (found) begin
          credit_d = {1'b1, CREDIT_DEST, pick, 8'(pick_cnt), 32'h0};
          rr_d     = pick;
          sel_d    = pick;
          cnt_d    = pick_cnt;
          state_d  = StSend;
        end
      end
      StSend: begin
        if (credit_ready) begin
          // Pops that landed after the packet was latched stay in the counter.
          for (int p = 0; p < int'(NUM_PORTS); p++) begin
            if (sel_q == 3'(p)) begin
              freed_d[p] = freed_q[p] - cnt_q + ptr_t'(pop[p]);
            end
          end
          credit_d = '0;
          state_d  = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Credit FSM state and freed-slot counters
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= StIdle;
      rr_q     <= 3'(NUM_PORTS - 1);
      sel_q    <= '0;
      cnt_q    <= '0;
      credit_q <= '0;
      for (int p = 0; p < int'(NUM_PORTS); p++) begin
        freed_q[p] <= '0;
      end
    end else begin
      state_q  <= state_d;
      rr_q     <= rr_d;
      sel_q    <= sel_d;
      cnt_q    <= cnt_d;
      credit_q <= credit_d;
      for (int p = 0; p < int'(NUM_PORTS); p++) begin
        freed_q[p] <= freed_d[p];
      end
    end
  end

  assign credit_out   = credit_q;
  assign err_overflow = err_overflow_q;
  assign err_misroute = err_misroute_q;
  assign drop_count   = drop_count_q;

endmodule
